// File: rtl/ysyx_23060201_mem_reader_pkg.sv
// Shared load-path definitions: RV32 load funct3 codes, reader FSM states,
// and the accept-time legality check.
// Pure declarations; no timing or flow control of its own.
package ysyx_23060201_mem_reader_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  // A request is bad when funct3 is not a load, or when the access is not
  // naturally aligned for its size. Bad requests never touch memory.
  function automatic logic ld_req_err(input logic [2:0] funct3, input logic [1:0] lane);
    case (funct3)
      F3_LB, F3_LBU: ld_req_err = 1'b0;
      F3_LH, F3_LHU: ld_req_err = lane[0];
      F3_LW:         ld_req_err = |lane;
      default:       ld_req_err = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_23060201_mem_reader_if.sv
// Bundle of the LSU load request/response link and the physical-memory read port.
// Wires only; latency is set by whoever drives the modports.
// Handshakes: ld_valid/ld_ready, res_valid/res_ready; memory side is strobe + valid.
interface ysyx_23060201_mem_reader_if #(
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH     = 32
);
  logic                      ld_valid;
  logic                      ld_ready;
  logic [MEM_ADDR_WIDTH-1:0] ld_addr;
  logic [2:0]                ld_funct3;
  logic                      res_valid;
  logic                      res_ready;
  logic [DATA_WIDTH-1:0]     res_data;
  logic                      res_err;
  logic                      mem_ren;
  logic [MEM_ADDR_WIDTH-1:0] mem_raddr;
  logic                      mem_rvalid;
  logic [DATA_WIDTH-1:0]     mem_rdata;

  // The reader itself.
  modport slave (
    input  ld_valid, ld_addr, ld_funct3, res_ready, mem_rvalid, mem_rdata,
    output ld_ready, res_valid, res_data, res_err, mem_ren, mem_raddr
  );

  // The LSU plus memory model facing the reader.
  modport master (
    output ld_valid, ld_addr, ld_funct3, res_ready, mem_rvalid, mem_rdata,
    input  ld_ready, res_valid, res_data, res_err, mem_ren, mem_raddr
  );
endinterface

// File: rtl/ysyx_23060201_load_extract.sv
// Picks the addressed byte/halfword/word out of an aligned memory word and extends it.
// Purely combinational, zero cycles.
// No flow control; caller qualifies the output.
module ysyx_23060201_load_extract
  import ysyx_23060201_mem_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [1:0]            lane,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Halfwords only ever sit at lane 0 or 2, so lane[1] alone picks them.
  assign byte_sel = word[{lane, 3'b000} +: 8];
  assign half_sel = word[{lane[1], 4'b0000} +: 16];

  // Sign- or zero-extend the selected field according to the load type.
  always_comb begin
    data = word;
    case (funct3)
      F3_LB:   data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      F3_LH:   data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      F3_LHU:  data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/ysyx_23060201_mem_reader.sv
// Single-outstanding load engine: word read from memory, extract/extend, return to writeback.
// Latency: 1 cycle for rejected requests, 2 + memory wait cycles otherwise (min 3).
// Holds the result until res_ready; ld_ready drops for the whole transaction.
module ysyx_23060201_mem_reader
  import ysyx_23060201_mem_reader_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  ysyx_23060201_mem_reader_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  state_t                    state_q, state_d;
  logic [1:0]                lane_q;
  logic [2:0]                funct3_q;
  logic [MEM_ADDR_WIDTH-1:0] raddr_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [CNT_W-1:0]          cnt_inc;
  logic [DATA_WIDTH-1:0]     res_data_q;
  logic                      res_err_q;
  logic [DATA_WIDTH-1:0]     ext_data;
  logic                      req_err;
  logic                      timed_out;
  logic                      ld_ready_c;
  logic                      res_valid_c;
  logic                      mem_ren_c;

  assign req_err   = ld_req_err(bus.ld_funct3, bus.ld_addr[1:0]);
  assign cnt_inc   = cnt_q + CNT_W'(1);
  // The wait cycle that brings the counter to the limit is the last one.
  assign timed_out = (cnt_inc == CNT_MAX);

  ysyx_23060201_load_extract #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_extract (
    .word   (bus.mem_rdata),
    .lane   (lane_q),
    .funct3 (funct3_q),
    .data   (ext_data)
  );

  // State register; reset drops any in-flight load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and handshake outputs; data arriving on the limit cycle still wins.
  always_comb begin
    state_d     = state_q;
    ld_ready_c  = 1'b0;
    res_valid_c = 1'b0;
    mem_ren_c   = 1'b0;
    case (state_q)
      IDLE: begin
        ld_ready_c = 1'b1;
        if (bus.ld_valid) state_d = req_err ? RESP : REQ;
      end
      REQ: begin
        mem_ren_c = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        if (bus.mem_rvalid || timed_out) state_d = RESP;
      end
      RESP: begin
        res_valid_c = 1'b1;
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch, wait counter and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q     <= 2'b00;
      funct3_q   <= 3'b000;
      raddr_q    <= '0;
      cnt_q      <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.ld_valid) begin
            lane_q     <= bus.ld_addr[1:0];
            funct3_q   <= bus.ld_funct3;
            raddr_q    <= {bus.ld_addr[MEM_ADDR_WIDTH-1:2], 2'b00};
            res_err_q  <= req_err;
            res_data_q <= '0;
          end
        end
        REQ: cnt_q <= '0;
        WAIT: begin
          if (bus.mem_rvalid) begin
            res_data_q <= ext_data;
            res_err_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_inc;
            if (timed_out) begin
              res_data_q <= '0;
              res_err_q  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ld_ready  = ld_ready_c;
  assign bus.res_valid = res_valid_c;
  assign bus.res_data  = res_data_q;
  assign bus.res_err   = res_err_q;
  assign bus.mem_ren   = mem_ren_c;
  assign bus.mem_raddr = raddr_q;

endmodule

// File: tb/tb_ysyx_23060201_mem_reader.sv
// Scoreboard bench: stimulus pushes expected results, a monitor pops and compares,
// and a memory responder answers reads with a per-request delay.
module tb_ysyx_23060201_mem_reader;

  localparam int TMO = 4;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    int          stall;
  } exp_t;

  typedef struct {
    logic [31:0] raddr;
    logic [31:0] word;
    int          d;
  } mem_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   stray_req = 0;
  int   stray_done = 0;

  exp_t exp_q[$];
  mem_t mem_q[$];
  int   acc_q[$];

  ysyx_23060201_mem_reader_if #(.MEM_ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  ysyx_23060201_mem_reader #(
    .MEM_ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic chk_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=no_event", name);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ld_ready"},  32'(bus.ld_ready),  32'd1);
    chk({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
    chk({tag, "_res_data"},  bus.res_data,       32'd0);
    chk({tag, "_res_err"},   32'(bus.res_err),   32'd0);
    chk({tag, "_mem_ren"},   32'(bus.mem_ren),   32'd0);
    chk({tag, "_mem_raddr"}, bus.mem_raddr,      32'd0);
  endtask

  // Reference behaviour from the load rules, with plain arithmetic.
  function automatic void model(input logic [31:0] addr, input logic [2:0] f3,
                                input logic [31:0] word, input int d,
                                output logic err, output logic [31:0] data, output bit rd);
    int size;
    bit sgn;
    bit legal;
    longint unsigned v;
    longint unsigned mask;
    legal = 1; size = 4; sgn = 0;
    case (f3)
      3'b000: begin size = 1; sgn = 1; end
      3'b001: begin size = 2; sgn = 1; end
      3'b010: begin size = 4; sgn = 0; end
      3'b100: begin size = 1; sgn = 0; end
      3'b101: begin size = 2; sgn = 0; end
      default: legal = 0;
    endcase
    err = 0; data = 0; rd = 0;
    if (!legal || (addr % size) != 0) begin err = 1; return; end
    rd = 1;
    if (d > TMO) begin err = 1; return; end
    mask = (64'd1 << (8 * size)) - 1;
    v = (longint'(word) >> (8 * (addr % 4))) & mask;
    if (sgn && ((v >> (8 * size - 1)) & 1) == 1) v = v | ~mask;
    data = v[31:0];
  endfunction

  task automatic issue(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] word,
                       input int d, input int stall, input bit push_exp);
    exp_t e;
    mem_t m;
    logic err;
    logic [31:0] data;
    bit rd;
    int n;
    model(addr, f3, word, d, err, data, rd);
    if (rd) begin
      m.raddr = addr & 32'hFFFF_FFFC;
      m.word  = word;
      m.d     = d;
      mem_q.push_back(m);
    end
    if (push_exp) begin
      e.data  = data;
      e.err   = err;
      e.lat   = !rd ? 1 : ((d < TMO ? d : TMO) + 2);
      e.stall = stall;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    bus.ld_valid  = 1'b1;
    bus.ld_addr   = addr;
    bus.ld_funct3 = f3;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.ld_ready) break;
      n++;
      if (n > 200) begin chk_fail("accept_timeout"); break; end
    end
    acc_q.push_back(cyc);
    @(posedge clk); #1;
    bus.ld_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) chk_fail("drain_timeout");
    repeat (2) @(negedge clk);
  endtask

  // Memory model: answers each strobe after its programmed delay, or never.
  initial begin
    mem_t m;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      if (stray_done != stray_req) begin
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = $urandom;
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
        stray_done++;
      end else if (!rst && bus.mem_ren) begin
        if (mem_q.size() == 0) chk_fail("unexpected_mem_ren");
        else begin
          m = mem_q.pop_front();
          chk("mem_raddr", bus.mem_raddr, m.raddr);
          if (m.d <= TMO) begin
            repeat (m.d) @(posedge clk);
            #1;
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = m.word;
            @(posedge clk); #1;
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = $urandom;
          end
        end
      end
    end
  end

  // Result monitor: applies backpressure, checks data, latency and stability.
  initial begin
    exp_t e;
    int a;
    bus.res_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !bus.res_valid) continue;
      if (exp_q.size() == 0) begin
        chk_fail("unexpected_res_valid");
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        continue;
      end
      e = exp_q[0];
      a = (acc_q.size() != 0) ? acc_q.pop_front() : -1000;
      chk("latency", 32'(cyc - a), 32'(e.lat));
      chk("res_data", bus.res_data, e.data);
      chk("res_err", 32'(bus.res_err), 32'(e.err));
      chk("ld_ready_busy", 32'(bus.ld_ready), 32'd0);
      for (int i = 0; i < e.stall; i++) begin
        @(negedge clk);
        chk("hold_valid", 32'(bus.res_valid), 32'd1);
        chk("hold_data", bus.res_data, e.data);
        chk("hold_err", 32'(bus.res_err), 32'(e.err));
        chk("hold_ld_ready", 32'(bus.ld_ready), 32'd0);
      end
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
      void'(exp_q.pop_front());
      @(negedge clk);
      chk("post_hs_ld_ready", 32'(bus.ld_ready), 32'd1);
      chk("post_hs_res_valid", 32'(bus.res_valid), 32'd0);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.ld_valid  = 1'b0;
    bus.ld_addr   = 32'h0;
    bus.ld_funct3 = 3'b000;
    #3;
    chk_reset_vals("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    issue(32'h8000_0004, 3'b010, 32'hDEAD_BEEF, 2, 0, 1);
    issue(32'h8000_0003, 3'b000, 32'h8012_3456, 1, 0, 1);
    issue(32'h8000_0003, 3'b100, 32'h8012_3456, 3, 0, 1);
    issue(32'h8000_0002, 3'b001, 32'h9ABC_0000, 1, 0, 1);
    issue(32'h8000_0001, 3'b001, 32'h9ABC_0000, 1, 0, 1);
    issue(32'h8000_0000, 3'b011, 32'h1111_2222, 1, 0, 1);
    issue(32'h8000_0006, 3'b010, 32'h1111_2222, 1, 0, 1);
    issue(32'h8000_0008, 3'b010, 32'h1234_5678, TMO, 0, 1);
    issue(32'h8000_000C, 3'b010, 32'h0000_0000, 99, 0, 1);
    drain();

    stray_req++;
    repeat (5) begin
      @(negedge clk);
      chk("stray_ignored", 32'(bus.res_valid), 32'd0);
    end

    issue(32'h8000_0010, 3'b101, 32'hF00D_CAFE, 2, 5, 1);

    for (int i = 0; i < 80; i++) begin
      logic [31:0] addr;
      addr = 32'h8000_0000 + $urandom_range(0, 255);
      issue(addr, 3'($urandom_range(0, 7)), $urandom, $urandom_range(1, 6),
            $urandom_range(0, 3), 1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    drain();

    issue(32'h8000_0020, 3'b010, 32'h1111_1111, 99, 0, 0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("reset_mid");
    @(negedge clk);
    rst = 1'b0;
    acc_q.delete();
    stray_req++;
    repeat (5) begin
      @(negedge clk);
      chk("stray_after_reset", 32'(bus.res_valid), 32'd0);
    end

    chk("queues_empty", 32'(exp_q.size() + mem_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_23060201_mem_reader.md
Name: ysyx_23060201_mem_reader

Overview:
- Load-side counterpart of the core's DPI-backed memory write path.
- Accepts one load request from the LSU, issues a word-aligned read on the physical-memory read port, and waits a variable number of cycles for the data.
- Extracts, aligns and sign/zero-extends the addressed byte, halfword or word, then hands the result to writeback.
- Sits between the EXU/LSU stage and the memory model (DPI `pmem_read` wrapper or bus bridge).

Parameters:
- MEM_ADDR_WIDTH, 32, width of load and memory addresses.
- DATA_WIDTH, 32, width of the memory data word and the result.
- TIMEOUT_CYCLES, 255, maximum cycles in WAIT before the load is aborted with an error; minimum 1.

Ports:
- clk  input  1  core clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- ld_valid  input  1  a load request is presented.
- ld_ready  output  1  the block can accept a request (IDLE only).
- ld_addr  input  MEM_ADDR_WIDTH  byte address of the load.
- ld_funct3  input  3  RV32 load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- res_valid  output  1  result is available.
- res_ready  input  1  consumer accepts the result.
- res_data  output  DATA_WIDTH  extended load result.
- res_err  output  1  qualifies res_valid; the load failed (misaligned, illegal funct3, or timeout).
- mem_ren  output  1  one-cycle read strobe.
- mem_raddr  output  MEM_ADDR_WIDTH  word address; low 2 bits always 0.
- mem_rvalid  input  1  read data is valid this cycle.
- mem_rdata  input  DATA_WIDTH  full aligned word.

Behaviour:
- Reset: the state machine goes to IDLE immediately (asynchronous). Output reset values:
  - ld_ready=1
  - res_valid=0, res_data=0, res_err=0
  - mem_ren=0, mem_raddr=0
  - timeout counter=0
- Request acceptance: a request is accepted when ld_valid && ld_ready. On acceptance the block latches addr[1:0], funct3 and the word address.
- Accept-time error checks:
  - Illegal funct3 (011, 110, 111) is an error.
  - Misalignment is an error: LH/LHU with addr[0]=1, or LW with addr[1:0]!=0.
  - On either error the block goes directly to RESP with res_err=1 and res_data=0. No memory read is issued.
- States:
  - IDLE:
    - ld_ready=1.
    - Accept with no error -> REQ.
    - Accept with error -> RESP.
  - REQ (one cycle):
    - mem_ren=1, mem_raddr={addr[31:2],2'b00}.
    - Timeout counter cleared.
    - -> WAIT.
  - WAIT:
    - mem_ren=0.
    - mem_rvalid=1: capture the extracted result -> RESP.
    - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES: res_err=1, res_data=0 -> RESP.
    - A mem_rvalid arriving in the same cycle the counter hits the limit wins; the result is good data.
  - RESP:
    - res_valid=1; res_data and res_err stay stable until the handshake.
    - res_ready=1 -> IDLE, with res_valid=0 on the next cycle.
- Throughput and latency:
  - The block handles one outstanding load. A new request is not accepted in the same cycle as the response handshake.
  - Minimum latency from acceptance to res_valid is 3 cycles (REQ, WAIT with rvalid, RESP).
- Stray mem_rvalid: ignored in IDLE, REQ and RESP.
- Extraction, with byte lane = addr[1:0]:
  - LB: sign-extend mem_rdata[8*lane+7 : 8*lane].
  - LBU: zero-extend the same byte.
  - LH: sign-extend the halfword at lane 0 or 2.
  - LHU: zero-extend the same halfword.
  - LW: full word.
- Reset mid-operation: all state is dropped. A later mem_rvalid is ignored because the block is in IDLE.

Decomposition:
- Shared defines header entries:
  - funct3 load encodings: LB, LH, LW, LBU, LHU.
  - state encodings: IDLE, REQ, WAIT, RESP.
- One natural sub-module: ysyx_23060201_load_extract. It is combinational: (word, lane, funct3) -> extended data. The same extractor can be reused later in the cache path.

Test Plan:
- LW: ld_addr=0x80000004, mem_rdata=0xDEADBEEF returned 2 cycles after mem_ren -> mem_raddr=0x80000004; res_data=0xDEADBEEF, res_err=0.
- LB and LBU, addr=0x80000003, mem_rdata=0x80123456:
  - LB -> res_data=0xFFFFFF80.
  - LBU -> res_data=0x00000080.
  - mem_raddr=0x80000000 for both.
- LH, addr=0x80000002, mem_rdata=0x9ABC0000 -> res_data=0xFFFF9ABC. Same request with LH at addr=0x80000001 -> no mem_ren, res_valid after 1 cycle, res_err=1, res_data=0.
- Timeout and stray data: with TIMEOUT_CYCLES=4 and no mem_rvalid -> res_err=1 after the counter reaches 4. A mem_rvalid pulsed afterwards while in IDLE is ignored: no res_valid.
- Backpressure: res_ready held 0 for 5 cycles -> res_valid and res_data stable, ld_ready=0. Then res_ready=1 -> IDLE and ld_ready=1 on the next cycle.
- Reset mid-operation: assert rst while in WAIT -> all outputs reach their reset values without waiting for a clock edge. A subsequent mem_rvalid does not produce res_valid.
